dp_ram_core: RTL and testbench
==============================

Name: dp_ram_core

Overview:
- Synthesizable dual-port RAM that serves as the design-under-test driven by the existing dual-port RAM verification environment (write-port and read-port agents).
- Provides one independent write port and one independent read port, with a 1-cycle registered read.
- A post-reset initialisation sweep clears every location.
- Same-address read/write collisions are resolved write-first and flagged.

Parameters:
- DATA_WIDTH, 8, width of each memory word.
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH locations (16 by default).
- INIT_VALUE, 0, word value written to every location during the init sweep.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- wr_en  input  1  write request, qualified by init_done.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- rd_en  input  1  read request, qualified by init_done.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  rd_data holds a valid read result this cycle.
- init_done  output  1  init sweep complete; the ports are live.
- collision  output  1  1-cycle pulse: accepted read and write to the same address in the same cycle.
- req_drop  output  1  1-cycle pulse: wr_en or rd_en asserted while init_done=0.

Behaviour:
- Reset: clk and rst_n as stated; reset is synchronous, active-low.
- Reset values: rd_data=0, rd_valid=0, init_done=0, collision=0, req_drop=0, FSM=INIT, init pointer=0.
- Memory contents are not reset directly; the INIT sweep clears them.
- FSM states:
  - INIT: each cycle writes INIT_VALUE to mem[ptr] and increments ptr. When ptr==DEPTH-1 is written, go to READY the next cycle. The sweep takes exactly DEPTH cycles.
  - READY: init_done=1; normal operation.
- Reset mid-operation: rst_n low in any state returns to INIT with ptr=0 and re-runs the full sweep. Any in-flight read is discarded (rd_valid=0).
- Requests during INIT:
  - wr_en/rd_en are ignored; memory is unchanged except by the sweep.
  - req_drop=1 on the following cycle; rd_valid stays 0.
- Write (READY, wr_en=1): mem[wr_addr] <= wr_data at this edge.
- Read (READY, rd_en=1, cycle N): rd_data = mem[rd_addr] and rd_valid=1 in cycle N+1.
- rd_valid=0 in any cycle whose previous cycle had no accepted read.
- rd_data holds its last value when rd_valid=0.
- Back-to-back reads: one result per cycle, in order, no bubbles.
- Simultaneous read and write:
  - Different addresses: fully independent.
  - Same address: write-first. rd_data in N+1 equals the wr_data of cycle N, and collision=1 in N+1.
- Read-after-write to the same address in the next cycle returns the new data (no hazard).
- collision and req_drop are registered pulses, exactly 1 cycle wide per event. They re-assert each cycle while the condition persists.
- Address wrap: the full ADDR_WIDTH range is valid; no out-of-range case exists.
- Arithmetic: only the init pointer counts. It is ADDR_WIDTH+1 bits wide internally so the terminal compare cannot alias.

Test Plan:
- Init sweep: deassert rst_n after 3 cycles → init_done rises exactly 16 cycles later. Read all addresses 0..15 → each returns 0x00 with rd_valid one cycle after rd_en.
- Write/read: write 0xA5@3 and 0x5A@12, then read 3 and 12 back-to-back → rd_data = 0xA5 then 0x5A on consecutive cycles, rd_valid high both cycles.
- Collision: addr 7 holds 0x11; in one cycle issue wr 0x22@7 and rd@7 → next cycle rd_data=0x22, collision=1. Repeat with wr@7/rd@8 → collision=0.
- Early requests: assert wr_en (0xFF@2) and rd_en during INIT cycle 5 → req_drop=1 next cycle, rd_valid=0. After init, read 2 → 0x00.
- Mid-operation reset: fill 0..15 with 0x10+i, pulse rst_n low for 1 cycle during a read burst → rd_valid drops, init_done=0 for 16 cycles. All locations then read back 0x00.
- Back-to-back stress: 32 consecutive random reads/writes with the reference model checking → every rd_data matches the model, and collision asserts only on same-address cycles.

Source files
------------

// File: rtl/dp_ram_core.sv
// dp_ram_core: dual-port RAM with one write port and one registered read port.
// After every reset a sweep writes INIT_VALUE to each location. The ports are
// live only once init_done is high. A read and a write to the same address in
// the same cycle resolve write-first, and the collision output flags the event.

module dp_ram_core #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  init_done,
    output logic                  collision,
    output logic                  req_drop
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // The pointer has one extra bit, so the terminal compare never aliases with a wrapped value.
    localparam logic [ADDR_WIDTH:0] PTR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  collision_q, collision_d;
    logic                  req_drop_q, req_drop_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  ready;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  same_addr;

    assign ready     = (state_q == ST_READY);
    assign wr_accept = ready && wr_en;
    assign rd_accept = ready && rd_en;
    assign same_addr = (wr_addr == rd_addr);

    // Next-state logic: sweep sequencing, write-port steering, write-first read data and event pulses.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        collision_d = 1'b0;
        req_drop_d  = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = wr_addr;
        mem_wdata   = wr_data;

        if (state_q == ST_INIT) begin
            // The sweep owns the write port. User requests are dropped and flagged.
            mem_we     = 1'b1;
            mem_waddr  = ptr_q[ADDR_WIDTH-1:0];
            mem_wdata  = INIT_VALUE;
            ptr_d      = ptr_q + PTR_ONE;
            req_drop_d = wr_en || rd_en;
            if (ptr_q == PTR_LAST) begin
                state_d = ST_READY;
            end
        end else begin
            mem_we = wr_accept;
            if (rd_accept) begin
                rd_valid_d = 1'b1;
                if (wr_accept && same_addr) begin
                    // The array still holds the old word at this edge, so bypass the incoming data.
                    rd_data_d   = wr_data;
                    collision_d = 1'b1;
                end else begin
                    rd_data_d = mem[rd_addr];
                end
            end
        end
    end

    // Memory array write. Contents are not reset; a write is blocked while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control and output registers. Reset restarts the sweep and discards any in-flight read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            collision_q <= 1'b0;
            req_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            collision_q <= collision_d;
            req_drop_q  <= req_drop_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign init_done = ready;
    assign collision = collision_q;
    assign req_drop  = req_drop_q;

endmodule

// File: tb/tb_dp_ram_core.sv
// tb_dp_ram_core: self-checking bench for dp_ram_core.
// A behavioural memory model predicts every output on every cycle. Table vectors and
// hand-written sequences add explicit expectations for the corner cases.

module tb_dp_ram_core;

    localparam int          DW       = 8;
    localparam int          AW       = 4;
    localparam int          DEPTH    = 16;
    localparam logic [DW-1:0] INIT_VAL = 8'h00;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          init_done;
    logic          collision;
    logic          req_drop;

    int checks = 0;
    int errors = 0;

    // Behavioural model: memory contents plus the outputs expected after each edge.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_ready;
    int            m_swept;
    logic [DW-1:0] e_data;
    bit            e_valid;
    bit            e_coll;
    bit            e_drop;

    typedef struct {
        bit          w;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit          r;
        logic [AW-1:0] ra;
        bit          ev;
        logic [DW-1:0] ed;
        bit          ec;
    } vec_t;

    vec_t vecs [9];

    dp_ram_core #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .INIT_VALUE (INIT_VAL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .init_done (init_done),
        .collision (collision),
        .req_drop  (req_drop)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the model by one edge. The write is applied before the read, which gives write-first behaviour.
    task automatic modelEdge();
        if (!rst_n) begin
            m_ready = 0;
            m_swept = 0;
            e_data  = '0;
            e_valid = 0;
            e_coll  = 0;
            e_drop  = 0;
        end else if (!m_ready) begin
            m_mem[m_swept] = INIT_VAL;
            m_swept++;
            if (m_swept == DEPTH) m_ready = 1;
            e_valid = 0;
            e_coll  = 0;
            e_drop  = wr_en || rd_en;
        end else begin
            e_drop = 0;
            if (wr_en) m_mem[wr_addr] = wr_data;
            e_valid = rd_en;
            e_coll  = wr_en && rd_en && (wr_addr == rd_addr);
            if (rd_en) e_data = m_mem[rd_addr];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("model_rd_data",   rd_data,   e_data);
        checkOutput("model_rd_valid",  rd_valid,  e_valid);
        checkOutput("model_init_done", init_done, m_ready);
        checkOutput("model_collision", collision, e_coll);
        checkOutput("model_req_drop",  req_drop,  e_drop);
    endtask

    task automatic applyStimulus(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input bit r, input logic [AW-1:0] ra);
        wr_en   = w;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = r;
        rd_addr = ra;
        tick();
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
    endtask

    // Idle until init_done rises, with a cycle budget, and report how many cycles that took.
    task automatic waitInit(output int cycles);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            cycles++;
            if (init_done === 1'b1) break;
        end
    endtask

    task automatic readAllZero(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, AW'(a));
            checkOutput({tag, "_valid"}, rd_valid, 1'b1);
            checkOutput({tag, "_data"},  rd_data,  INIT_VAL);
        end
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;

        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hEE;
        m_ready = 0; m_swept = 0; e_data = '0; e_valid = 0; e_coll = 0; e_drop = 0;

        //          w    wa     wd     r    ra     ev   ed     ec
        vecs[0] = '{1'b1, 4'd3,  8'hA5, 1'b0, 4'd0,  1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 4'd12, 8'h5A, 1'b0, 4'd0,  1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  1'b1, 8'hA5, 1'b0};
        vecs[3] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd12, 1'b1, 8'h5A, 1'b0};
        vecs[4] = '{1'b1, 4'd7,  8'h11, 1'b0, 4'd0,  1'b0, 8'h5A, 1'b0};
        vecs[5] = '{1'b1, 4'd7,  8'h22, 1'b1, 4'd7,  1'b1, 8'h22, 1'b1};
        vecs[6] = '{1'b1, 4'd7,  8'h33, 1'b1, 4'd8,  1'b1, 8'h00, 1'b0};
        vecs[7] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd7,  1'b1, 8'h33, 1'b0};
        vecs[8] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  1'b0, 8'h33, 1'b0};

        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;

        $display("[TB] reset and init sweep");
        for (int i = 0; i < 3; i++) idle();
        checkOutput("reset_init_done", init_done, 1'b0);
        checkOutput("reset_rd_data",   rd_data,   8'h00);
        rst_n = 1'b1;

        // Requests issued in sweep cycle 5 must be dropped and flagged.
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) begin
                applyStimulus(1'b1, 4'd2, 8'hFF, 1'b1, 4'd2);
                checkOutput("early_req_drop", req_drop, 1'b1);
                checkOutput("early_rd_valid", rd_valid, 1'b0);
            end else begin
                idle();
                if (i == 6) checkOutput("early_drop_pulse", req_drop, 1'b0);
            end
            cycles++;
            if (init_done === 1'b1) break;
        end
        checkOutput("init_sweep_len", cycles, 16);

        $display("[TB] read all after init");
        readAllZero("init_read");

        $display("[TB] table vectors");
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].w, vecs[v].wa, vecs[v].wd, vecs[v].r, vecs[v].ra);
            checkOutput($sformatf("vec%0d_valid", v), rd_valid,  vecs[v].ev);
            checkOutput($sformatf("vec%0d_data", v),  rd_data,   vecs[v].ed);
            checkOutput($sformatf("vec%0d_coll", v),  collision, vecs[v].ec);
        end

        $display("[TB] mid-operation reset");
        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, AW'(a), 8'h10 + 8'(a), 1'b0, '0);
        for (int a = 0; a < DEPTH; a++) begin
            if (a == 6) rst_n = 1'b0;
            applyStimulus(1'b0, '0, '0, 1'b1, AW'(a));
            if (a < 6) begin
                checkOutput("burst_data", rd_data, 8'h10 + 8'(a));
            end else begin
                rst_n = 1'b1;
                checkOutput("midrst_rd_valid",  rd_valid,  1'b0);
                checkOutput("midrst_init_done", init_done, 1'b0);
                break;
            end
        end
        waitInit(cycles);
        checkOutput("midrst_sweep_len", cycles, 16);
        readAllZero("midrst_read");

        $display("[TB] random stress");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom),
                          1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)));
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
